moving_avg_win: RTL and testbench

//  Sliding-window averager. Sits directly downstream of the 8-bit sample delay line.

---
 rtl/moving_avg_win.sv | 75 +++++++
 tb/tb_moving_avg_win.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/moving_avg_win.sv
// Sliding-window averager: keeps the last 2^LOG2_N samples and a running sum,
// emitting sum and floor average one cycle after each accepted sample.
module moving_avg_win #(
    parameter int unsigned DW     = 8,
    parameter int unsigned LOG2_N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW+LOG2_N-1:0] out_sum,
    output logic [DW-1:0]        out_avg,
    output logic                 primed
);

    localparam int unsigned N  = 1 << LOG2_N;
    localparam int unsigned SW = DW + LOG2_N;

    logic [DW-1:0]     win_mem [N];
    logic [LOG2_N-1:0] wr_ptr_q;
    logic [LOG2_N:0]   fill_q, fill_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic              accept;
    logic              full;
    logic [DW-1:0]     old;

    always_comb begin
        in_ready = ~clear & (~out_valid | out_ready);
        accept   = in_valid & in_ready;
        // fill never exceeds N, so its MSB alone marks a full window
        full     = fill_q[LOG2_N];
        old      = win_mem[wr_ptr_q];
        sum_d    = sum_q + SW'(in_data) - (full ? SW'(old) : '0);
        fill_d   = full ? fill_q : fill_q + {{LOG2_N{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_avg   <= '0;
            primed    <= 1'b0;
        end else if (clear) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            wr_ptr_q  <= wr_ptr_q + {{(LOG2_N-1){1'b0}}, 1'b1};
            fill_q    <= fill_d;
            sum_q     <= sum_d;
            out_valid <= 1'b1;
            out_sum   <= sum_d;
            out_avg   <= sum_d[SW-1:LOG2_N];
            primed    <= fill_d[LOG2_N];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sample storage is not reset; stale entries are masked by fill.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            win_mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_moving_avg_win.sv
// Self-checking bench for moving_avg_win: directed cases plus a randomized
// stream compared against a queue-based window model.
module tb_moving_avg_win;

    localparam int unsigned DW     = 8;
    localparam int unsigned LOG2_N = 3;
    localparam int unsigned N      = 8;

    logic                 clk = 1'b0;
    logic                 rst, clear, in_valid, in_ready;
    logic                 out_valid, out_ready, primed;
    logic [DW-1:0]        in_data, out_avg;
    logic [DW+LOG2_N-1:0] out_sum;

    int checks = 0;
    int errors = 0;

    // Reference model: window contents and the output the DUT should present
    int unsigned win[$];
    bit          m_ovalid;
    int unsigned m_sum;
    bit          m_primed;

    moving_avg_win #(.DW(DW), .LOG2_N(LOG2_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        win.delete();
        m_ovalid = 1'b0;
    endtask

    // One clock cycle: drive inputs, check the presented state against the
    // model, advance the model, then step past the next rising edge.
    task automatic cyc(input bit v, input int unsigned d, input bit ordy, input bit clr);
        bit exp_ready;
        bit acc;
        in_valid = v; in_data = d[7:0]; out_ready = ordy; clear = clr;
        #1;
        exp_ready = !clr && (!m_ovalid || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(m_ovalid));
        if (m_ovalid) begin
            chk("out_sum", 32'(out_sum), m_sum);
            chk("out_avg", 32'(out_avg), m_sum / N);
            chk("primed", 32'(primed), 32'(m_primed));
        end
        acc = v && exp_ready;
        if (clr) begin
            win.delete();
            m_ovalid = 1'b0;
        end else if (acc) begin
            win.push_back(d);
            if (win.size() > N) void'(win.pop_front());
            m_sum = 0;
            foreach (win[i]) m_sum += win[i];
            m_primed = (win.size() == N);
            m_ovalid = 1'b1;
        end else if (ordy) begin
            m_ovalid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned t2_sum[8] = '{1, 3, 6, 10, 15, 21, 28, 36};
        int unsigned t2_avg[8] = '{0, 0, 0, 1, 1, 2, 3, 4};
        logic [31:0] held;

        // T1 reset
        do_reset();
        #1;
        chk("t1_out_valid", 32'(out_valid), 0);
        chk("t1_out_sum", 32'(out_sum), 0);
        chk("t1_out_avg", 32'(out_avg), 0);
        chk("t1_primed", 32'(primed), 0);
        chk("t1_in_ready", 32'(in_ready), 1);

        // T2 ramp
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, i + 1, 1'b1, 1'b0);
            chk("t2_sum", 32'(out_sum), t2_sum[i]);
            chk("t2_avg", 32'(out_avg), t2_avg[i]);
            chk("t2_primed", 32'(primed), (i == 7) ? 1 : 0);
        end

        // T3 wrap
        cyc(1'b1, 9, 1'b1, 1'b0);
        chk("t3_sum9", 32'(out_sum), 44);
        chk("t3_avg9", 32'(out_avg), 5);
        chk("t3_primed9", 32'(primed), 1);
        cyc(1'b1, 10, 1'b1, 1'b0);
        chk("t3_sum10", 32'(out_sum), 52);
        chk("t3_avg10", 32'(out_avg), 6);
        chk("t3_primed10", 32'(primed), 1);
        cyc(1'b0, 0, 1'b1, 1'b0);

        // T4 full scale
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 255, 1'b1, 1'b0);
            if (i >= 7) begin
                chk("t4_sum", 32'(out_sum), 2040);
                chk("t4_avg", 32'(out_avg), 255);
            end
        end

        // T5 backpressure: output pending, downstream stalled
        held = 32'(out_sum);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 17 + i, 1'b0, 1'b0);
            chk("t5_hold", 32'(out_sum), held);
        end
        cyc(1'b1, 40, 1'b1, 1'b0);
        chk("t5_resume", 32'(out_sum), 2040 - 255 + 40);
        cyc(1'b1, 41, 1'b1, 1'b0);

        // T6 clear mid-window with a sample offered
        cyc(1'b1, 99, 1'b1, 1'b1);
        cyc(1'b1, 7, 1'b1, 1'b0);
        chk("t6_sum", 32'(out_sum), 7);
        chk("t6_avg", 32'(out_avg), 0);
        chk("t6_primed", 32'(primed), 0);
        cyc(1'b0, 0, 1'b1, 1'b0);

        // Randomized stream against the model
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom_range(0, 255),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
        end
        cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
